// File: rtl/tx_arb_pkg.sv
// tx_arb_pkg
//   Shared types and helpers for the UART transmit arbiter.
//   - state_e : arbiter FSM states
//   - DATA_W  : width of one transmitted byte
//   - clog2() : bit width needed to hold the values 0..v-1 (minimum 1)
package tx_arb_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BYTE = 2'd1,
        SEND      = 2'd2,
        WAIT_DONE = 2'd3
    } state_e;

    function automatic int clog2(input int v);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < v) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick
//   Combinational round-robin priority selector. The search starts at the
//   entry just above ptr_i and wraps modulo N; the first set request wins.
//   Ports:
//     req_i [N-1:0]  request vector
//     ptr_i [PW-1:0] index of the most recently served entry
//     gnt_o [N-1:0]  one-hot winner (all zero when no request)
//     any_o          at least one request is set
module rr_pick #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic          any_o
);

    always_comb begin
        int idx;
        idx   = 0;
        gnt_o = '0;
        any_o = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr_i) + k) % N;
            if (!any_o && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                any_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tx_arbiter.sv
// tx_arbiter
//   Shares one UART transmit core among NUM_REQ byte-stream requesters.
//   Ownership is granted round-robin per message and held until the byte
//   flagged last has left the core. A watchdog revokes an owner that leaves
//   the core idle for TIMEOUT_CYC cycles while a byte is expected.
//   Ports:
//     clk, rst              clock, synchronous active-high reset
//     reqValid/reqData/     per-requester byte offer (data slice i at
//     reqLast/reqReady        [8i+7:8i]); handshake is reqValid & reqReady
//     grant                 one-hot owner, zero when idle
//     txEn/txData           one-cycle start pulse and byte to the core
//     txBusy/txDone         core shifting / end-of-stop-bit pulse
//     timeoutErr            one-cycle pulse when the watchdog revokes a grant
module tx_arbiter
    import tx_arb_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          reqValid,
    input  logic [DATA_W*NUM_REQ-1:0]   reqData,
    input  logic [NUM_REQ-1:0]          reqLast,
    output logic [NUM_REQ-1:0]          reqReady,
    output logic [NUM_REQ-1:0]          grant,
    output logic                        txEn,
    output logic [DATA_W-1:0]           txData,
    input  logic                        txBusy,
    input  logic                        txDone,
    output logic                        timeoutErr
);

    localparam int PW = clog2(NUM_REQ);
    localparam int CW = clog2(TIMEOUT_CYC);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYC - 1);

    state_e              state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                last_q, last_d;

    logic [NUM_REQ-1:0]  pick_gnt;
    logic                pick_any;
    logic [PW-1:0]       own;
    logic                hs;
    logic                wd_fire;

    rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
        .req_i (reqValid),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .any_o (pick_any)
    );

    // Owner index recovered from the one-hot grant.
    always_comb begin
        own = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) own = PW'(i);
        end
    end

    // A handshake in the last watchdog cycle wins: the requester has already
    // seen its byte accepted, so the grant must not be revoked under it.
    assign hs      = (state_q == WAIT_BYTE) && !txBusy && reqValid[own];
    assign wd_fire = (state_q == WAIT_BYTE) && (cnt_q == CNT_MAX) && !hs;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        last_d  = last_q;
        cnt_d   = '0;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick_gnt;
                    state_d = WAIT_BYTE;
                end
            end
            WAIT_BYTE: begin
                if (hs) begin
                    data_d  = reqData[int'(own)*DATA_W +: DATA_W];
                    last_d  = reqLast[own];
                    state_d = SEND;
                end else if (wd_fire) begin
                    grant_d = '0;
                    ptr_d   = own;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SEND: begin
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (txDone) begin
                    if (last_q) begin
                        grant_d = '0;
                        ptr_d   = own;
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT_BYTE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= PW'(NUM_REQ - 1);
            cnt_q   <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    // Ready depends only on state, owner and txBusy so a requester can never
    // create a combinational loop through reqValid.
    assign reqReady   = (state_q == WAIT_BYTE && !txBusy) ? grant_q : '0;
    assign grant      = grant_q;
    assign txEn       = (state_q == SEND);
    assign txData     = txEn ? data_q : '0;
    assign timeoutErr = wd_fire;

endmodule

// File: tb/tb_tx_arbiter.sv
// tb_tx_arbiter
//   Randomized and directed stimulus for tx_arbiter with a message-level
//   reference model (owner, byte-held, byte-in-flight, idle counter) and a
//   simple transmit-core model.
module tb_tx_arbiter;

    localparam int N = 3;
    localparam int T = 50;

    logic           clk, rst;
    logic [N-1:0]   reqValid, reqLast, reqReady, grant;
    logic [8*N-1:0] reqData;
    logic           txEn, txBusy, txDone, timeoutErr;
    logic [7:0]     txData;

    tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(T)) dut (
        .clk(clk), .rst(rst),
        .reqValid(reqValid), .reqData(reqData), .reqLast(reqLast),
        .reqReady(reqReady), .grant(grant),
        .txEn(txEn), .txData(txData),
        .txBusy(txBusy), .txDone(txDone),
        .timeoutErr(timeoutErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0, n_bad = 0, cyc = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic chk_q(input string tag, input int got[$], input int exp[$]);
        chk({tag, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++) chk(tag, got[i], exp[i]);
    endtask

    // requester scripts: {last, data}
    logic [8:0] rq [N][$];
    int         gap [N];
    bit         rnd = 0;

    // reference model
    int         m_own = -1, m_ptr = N - 1, m_cnt = 0;
    bit         m_hold = 0, m_fly = 0, m_last = 0;
    logic [7:0] m_byte = 0;

    // transmit core model
    int busy_cnt = 0, force_busy = 0, core_len = 10;
    bit core_rand = 0;

    // observations
    logic [N-1:0] hs_mask = '0, prev_gnt = '0;
    bit           saw_en = 0;
    int           tx_log[$], en_cyc[$], gnt_log[$], to_cyc[$], done_cyc[$], exq[$];
    int           ready_busy = 0;

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v = '0;
        if (i >= 0) v[i] = 1'b1;
        return v;
    endfunction

    function automatic bit quiet();
        bit q;
        q = (m_own < 0) && (busy_cnt == 0) && (force_busy == 0);
        for (int i = 0; i < N; i++) if (rq[i].size() != 0) q = 0;
        return q;
    endfunction

    task automatic drive();
        logic [8:0] h;
        for (int i = 0; i < N; i++) begin
            if (rq[i].size() > 0 && gap[i] == 0) begin
                h = rq[i][0];
                reqValid[i]       = 1'b1;
                reqData[i*8 +: 8] = h[7:0];
                reqLast[i]        = h[8];
            end else begin
                reqValid[i]       = 1'b0;
                reqData[i*8 +: 8] = 8'($urandom);
                reqLast[i]        = 1'($urandom);
            end
        end
    endtask

    task automatic model_update();
        bit found;
        int idx;
        if (rst) begin
            m_own = -1; m_ptr = N - 1; m_cnt = 0; m_hold = 0; m_fly = 0;
        end else if (m_own < 0) begin
            found = 0;
            for (int k = 1; k <= N; k++) begin
                idx = (m_ptr + k) % N;
                if (!found && reqValid[idx]) begin
                    m_own = idx; found = 1;
                end
            end
            m_cnt = 0;
        end else if (m_hold) begin
            m_hold = 0; m_fly = 1;
        end else if (m_fly) begin
            if (txDone) begin
                m_fly = 0; m_cnt = 0;
                if (m_last) begin m_ptr = m_own; m_own = -1; end
            end
        end else begin
            if (!txBusy && reqValid[m_own]) begin
                m_byte = reqData[m_own*8 +: 8];
                m_last = reqLast[m_own];
                m_hold = 1; m_cnt = 0;
            end else if (m_cnt == T - 1) begin
                m_ptr = m_own; m_own = -1; m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic core_advance();
        txDone = 1'b0;
        if (rst) begin
            busy_cnt = 0;
        end else if (saw_en) begin
            busy_cnt = core_rand ? int'($urandom_range(2, 12)) : core_len;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) txDone = 1'b1;
        end else if (core_rand && $urandom_range(0, 49) == 0) begin
            txDone = 1'b1;   // stray pulse while idle
        end
        if (force_busy > 0) force_busy--;
        else if (core_rand && busy_cnt == 0 && $urandom_range(0, 59) == 0)
            force_busy = $urandom_range(1, 25);
        txBusy = (busy_cnt > 0) || (force_busy > 0);
    endtask

    task automatic step();
        logic [N-1:0] eg, er;
        bit wait_b, mhs;
        @(negedge clk);
        wait_b = (m_own >= 0) && !m_hold && !m_fly;
        eg     = onehot(m_own);
        er     = (wait_b && !txBusy) ? eg : '0;
        mhs    = 0;
        if (wait_b) mhs = !txBusy && reqValid[m_own];
        chk("grant", grant, eg);
        chk("reqReady", reqReady, er);
        chk("txEn", txEn, m_hold);
        if (m_hold) chk("txData", txData, m_byte);
        chk("timeoutErr", timeoutErr, wait_b && (m_cnt == T - 1) && !mhs);
        if (txEn) begin tx_log.push_back(int'(txData)); en_cyc.push_back(cyc); end
        if (grant != 0 && prev_gnt == 0)
            for (int i = 0; i < N; i++) if (grant[i]) gnt_log.push_back(i);
        prev_gnt = grant;
        if (timeoutErr) to_cyc.push_back(cyc);
        if (txDone) done_cyc.push_back(cyc);
        if (txBusy && reqReady != 0) ready_busy++;
        hs_mask = reqReady & reqValid;
        saw_en  = txEn;
        @(posedge clk);
        model_update();
        #1;
        cyc++;
        core_advance();
        for (int i = 0; i < N; i++) begin
            if (hs_mask[i] && rq[i].size() > 0) void'(rq[i].pop_front());
            if (gap[i] > 0) gap[i]--;
            else if (rnd && rq[i].size() > 0 && $urandom_range(0, 39) == 0)
                gap[i] = $urandom_range(1, 70);
            if (rnd && rq[i].size() == 0 && $urandom_range(0, 15) == 0) begin
                int len;
                len = $urandom_range(1, 4);
                for (int b = 0; b < len; b++) rq[i].push_back({(b == len - 1), 8'($urandom)});
            end
        end
        drive();
    endtask

    task automatic run_idle(input string tag, input int budget);
        bit ok;
        ok = 0;
        for (int n = 0; n < budget && !ok; n++) begin
            step();
            ok = quiet();
        end
        chk(tag, ok, 1);
    endtask

    task automatic clear_logs();
        tx_log.delete(); en_cyc.delete(); gnt_log.delete();
        to_cyc.delete(); done_cyc.delete(); ready_busy = 0;
    endtask

    task automatic push(input int r, input logic [7:0] d, input bit last);
        rq[r].push_back({last, d});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin rq[i].delete(); gap[i] = 0; end
        force_busy = 0;
        drive();
        step();
        step();
        chk("rst_grant", grant, 0);
        chk("rst_ready", reqReady, 0);
        chk("rst_txEn", txEn, 0);
        chk("rst_txData", txData, 0);
        chk("rst_timeout", timeoutErr, 0);
        rst = 1'b0;
        clear_logs();
    endtask

    initial begin
        int s0;
        bit reached;
        rst = 1'b1; reqValid = '0; reqData = '0; reqLast = '0;
        txBusy = 1'b0; txDone = 1'b0;
        for (int i = 0; i < N; i++) gap[i] = 0;
        @(posedge clk); #1;

        // single owner, three-byte message
        do_reset();
        core_len = 10;
        push(0, 8'h31, 0); push(0, 8'h32, 0); push(0, 8'h33, 1);
        drive();
        s0 = cyc;
        run_idle("t1_idle", 400);
        exq = {32'h31, 32'h32, 32'h33};
        chk_q("t1_data", tx_log, exq);
        if (en_cyc.size() > 0) chk("t1_latency", en_cyc[0] - s0, 2);
        exq = {0};
        chk_q("t1_gnt", gnt_log, exq);
        chk("t1_grant_end", grant, 0);

        // contention from reset
        do_reset();
        push(0, 8'h11, 0); push(0, 8'h12, 1);
        push(1, 8'h21, 0); push(1, 8'h22, 1);
        drive();
        run_idle("t2_idle", 400);
        exq = {32'h11, 32'h12, 32'h21, 32'h22};
        chk_q("t2_data", tx_log, exq);
        exq = {0, 1};
        chk_q("t2_gnt", gnt_log, exq);

        // fairness: req0 keeps requesting
        do_reset();
        core_len = 4;
        for (int m = 0; m < 4; m++) push(0, 8'(8'hA0 + m), 1);
        push(1, 8'hB0, 1); push(1, 8'hB1, 1);
        drive();
        run_idle("t3_idle", 400);
        exq = {0, 1, 0, 1, 0, 0};
        chk_q("t3_gnt", gnt_log, exq);
        exq = {32'hA0, 32'hB0, 32'hA1, 32'hB1, 32'hA2, 32'hA3};
        chk_q("t3_data", tx_log, exq);

        // watchdog: req0 stalls mid-message, req1 pending
        do_reset();
        core_len = 10;
        push(0, 8'h55, 0);
        push(1, 8'h66, 1);
        drive();
        run_idle("t4_idle", 400);
        chk("t4_to_count", to_cyc.size(), 1);
        if (to_cyc.size() > 0 && done_cyc.size() > 0)
            chk("t4_to_delay", to_cyc[0] - done_cyc[0], T);
        exq = {0, 1};
        chk_q("t4_gnt", gnt_log, exq);
        exq = {32'h55, 32'h66};
        chk_q("t4_data", tx_log, exq);

        // stall: core busy for 20 cycles while the byte is offered
        do_reset();
        push(0, 8'h77, 1);
        force_busy = 20;
        txBusy = 1'b1;
        drive();
        s0 = cyc;
        run_idle("t5_idle", 400);
        chk("t5_ready_busy", ready_busy, 0);
        chk("t5_count", en_cyc.size(), 1);
        if (en_cyc.size() > 0) chk("t5_en_cyc", en_cyc[0] - s0, 21);

        // reset in WAIT_DONE of byte 2 of 3
        do_reset();
        push(0, 8'h41, 0); push(0, 8'h42, 0); push(0, 8'h43, 1);
        drive();
        reached = 0;
        for (int n = 0; n < 300 && !reached; n++) begin
            step();
            reached = (tx_log.size() == 2) && m_fly;
        end
        chk("t6_reach", reached, 1);
        rst = 1'b1;
        step();
        chk("t6_grant", grant, 0);
        chk("t6_ready", reqReady, 0);
        chk("t6_txEn", txEn, 0);
        chk("t6_txData", txData, 0);
        chk("t6_timeout", timeoutErr, 0);
        rst = 1'b0;
        for (int i = 0; i < N; i++) rq[i].delete();
        clear_logs();
        push(0, 8'h61, 1); push(1, 8'h62, 1);
        drive();
        run_idle("t6_idle", 400);
        exq = {0, 1};
        chk_q("t6_gnt", gnt_log, exq);
        exq = {32'h61, 32'h62};
        chk_q("t6_data", tx_log, exq);

        // random traffic against the model
        do_reset();
        core_rand = 1;
        rnd = 1;
        repeat (4000) step();
        rnd = 0;
        core_rand = 0;
        run_idle("rand_drain", 3000);
        chk("rand_traffic", tx_log.size() > 20, 1);
        chk("rand_timeouts", to_cyc.size() > 0, 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
